// File: rtl/fp_classify_pipe.sv
// Multi-lane pipelined FCLASS unit: one-hot 10-bit class per lane, NaN summary flags,
// valid/ready handshake with full backpressure and a configurable number of register stages.

package fp_pkg;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  function automatic int exp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32'sd8;
      FP64:    return 32'sd11;
      FP16:    return 32'sd5;
      BF16:    return 32'sd8;
      default: return 32'sd8;
    endcase
  endfunction

  function automatic int mant_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32'sd23;
      FP64:    return 32'sd52;
      FP16:    return 32'sd10;
      BF16:    return 32'sd7;
      default: return 32'sd23;
    endcase
  endfunction

  function automatic int fp_width(input fp_format_e fmt);
    return 32'sd1 + exp_width(fmt) + mant_width(fmt);
  endfunction
endpackage

module fp_classify_pipe
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT   = FP32,
  parameter int         LANES       = 4,
  parameter int         PIPE_STAGES = 2,
  parameter int         TAG_WIDTH   = 4,
  localparam int        FP_WIDTH    = fp_width(FP_FORMAT),
  localparam int        EXP_WIDTH   = exp_width(FP_FORMAT),
  localparam int        MANT_WIDTH  = mant_width(FP_FORMAT)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*FP_WIDTH-1:0] a_i,
  input  logic [LANES-1:0]          lane_en_i,
  input  logic [TAG_WIDTH-1:0]      tag_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*10-1:0]       class_o,
  output logic                      any_nan_o,
  output logic                      any_snan_o,
  output logic [TAG_WIDTH-1:0]      tag_o
);

  localparam int CW = LANES * 10;

  logic [CW-1:0]          class_s;
  logic                   any_nan_s;
  logic                   any_snan_s;
  logic [PIPE_STAGES-1:0] ready_s;
  logic [PIPE_STAGES-1:0] ld_valid_s;
  logic [PIPE_STAGES-1:0] ld_nan_s;
  logic [PIPE_STAGES-1:0] ld_snan_s;
  logic [CW-1:0]          ld_class_s [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   ld_tag_s   [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] valid_r;
  logic [PIPE_STAGES-1:0] nan_r;
  logic [PIPE_STAGES-1:0] snan_r;
  logic [CW-1:0]          class_r [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   tag_r   [PIPE_STAGES];

  function automatic logic [9:0] classify(input logic [FP_WIDTH-1:0] x);
    logic                  sign_v;
    logic [EXP_WIDTH-1:0]  exp_v;
    logic [MANT_WIDTH-1:0] mant_v;
    logic [9:0]            c_v;
    sign_v = x[FP_WIDTH-1];
    exp_v  = x[FP_WIDTH-2 -: EXP_WIDTH];
    mant_v = x[MANT_WIDTH-1:0];
    if (&exp_v) begin
      // NaN sign is irrelevant; mantissa MSB separates quiet from signalling
      if (mant_v == '0) begin
        c_v = sign_v ? 10'h001 : 10'h080;
      end else if (mant_v[MANT_WIDTH-1]) begin
        c_v = 10'h200;
      end else begin
        c_v = 10'h100;
      end
    end else if (exp_v == '0) begin
      if (mant_v == '0) begin
        c_v = sign_v ? 10'h008 : 10'h010;
      end else begin
        c_v = sign_v ? 10'h004 : 10'h020;
      end
    end else begin
      c_v = sign_v ? 10'h002 : 10'h040;
    end
    return c_v;
  endfunction

  // Per-lane classification and NaN flag reduction ahead of stage 0
  always_comb begin
    class_s    = '0;
    any_nan_s  = 1'b0;
    any_snan_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en_i[k]) begin
        class_s[k*10 +: 10] = classify(a_i[k*FP_WIDTH +: FP_WIDTH]);
      end else begin
        class_s[k*10 +: 10] = 10'h000;
      end
      any_nan_s  = any_nan_s | class_s[k*10 + 8] | class_s[k*10 + 9];
      any_snan_s = any_snan_s | class_s[k*10 + 8];
    end
  end

  // Stage k may load if any stage from k to the output is empty or the sink accepts
  always_comb begin
    ready_s = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      ready_s[k] = out_ready_i;
      for (int j = k; j < PIPE_STAGES; j++) begin
        ready_s[k] = ready_s[k] | ~valid_r[j];
      end
    end
  end

  // Load candidates for each stage: fresh classification for stage 0, predecessor otherwise
  always_comb begin
    ld_valid_s    = '0;
    ld_nan_s      = '0;
    ld_snan_s     = '0;
    ld_valid_s[0] = in_valid_i;
    ld_nan_s[0]   = any_nan_s;
    ld_snan_s[0]  = any_snan_s;
    ld_class_s[0] = class_s;
    ld_tag_s[0]   = tag_i;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      ld_valid_s[k] = valid_r[k-1];
      ld_nan_s[k]   = nan_r[k-1];
      ld_snan_s[k]  = snan_r[k-1];
      ld_class_s[k] = class_r[k-1];
      ld_tag_s[k]   = tag_r[k-1];
    end
  end

  // Pipeline registers; payload only moves on a stage accept
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_r <= '0;
      nan_r   <= '0;
      snan_r  <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        class_r[k] <= '0;
        tag_r[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (ready_s[k]) begin
          valid_r[k] <= ld_valid_s[k];
          if (ld_valid_s[k]) begin
            nan_r[k]   <= ld_nan_s[k];
            snan_r[k]  <= ld_snan_s[k];
            class_r[k] <= ld_class_s[k];
            tag_r[k]   <= ld_tag_s[k];
          end
        end
      end
    end
  end

  assign in_ready_o  = ready_s[0];
  assign out_valid_o = valid_r[PIPE_STAGES-1];
  assign class_o     = class_r[PIPE_STAGES-1];
  assign any_nan_o   = nan_r[PIPE_STAGES-1];
  assign any_snan_o  = snan_r[PIPE_STAGES-1];
  assign tag_o       = tag_r[PIPE_STAGES-1];

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Directed and randomized bench for fp_classify_pipe (FP32 x4 lanes, 2 stages) plus an FP16 build.
module tb_fp_classify_pipe;
  import fp_pkg::*;

  localparam int LANES = 4;
  localparam int P     = 2;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  a;
  logic [3:0]    lane_en;
  logic [TW-1:0] tag;
  logic          out_valid;
  logic          out_ready;
  logic [39:0]   class_o;
  logic          any_nan;
  logic          any_snan;
  logic [TW-1:0] tag_o;

  logic          h_valid;
  logic          h_ready;
  logic [15:0]   h_a;
  logic          h_out_valid;
  logic [9:0]    h_class;
  logic          h_nan;
  logic          h_snan;
  logic [0:0]    h_tag_o;

  always #5 clk = ~clk;

  fp_classify_pipe #(.FP_FORMAT(FP32), .LANES(LANES), .PIPE_STAGES(P), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .lane_en_i(lane_en), .tag_i(tag), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .class_o(class_o), .any_nan_o(any_nan),
    .any_snan_o(any_snan), .tag_o(tag_o)
  );

  fp_classify_pipe #(.FP_FORMAT(FP16), .LANES(1), .PIPE_STAGES(1), .TAG_WIDTH(1)) dut16 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(h_valid), .in_ready_o(h_ready),
    .a_i(h_a), .lane_en_i(1'b1), .tag_i(1'b1), .out_valid_o(h_out_valid),
    .out_ready_i(1'b1), .class_o(h_class), .any_nan_o(h_nan),
    .any_snan_o(h_snan), .tag_o(h_tag_o)
  );

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int accepts = 0;

  logic [39:0]   q_class[$];
  logic          q_nan[$];
  logic          q_snan[$];
  logic [TW-1:0] q_tag[$];

  logic          prev_hold = 1'b0;
  logic [39:0]   prev_class;
  logic          prev_nan;
  logic          prev_snan;
  logic [TW-1:0] prev_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Class index from field values: 0 -inf,1 -norm,2 -sub,3 -0,4 +0,5 +sub,6 +norm,7 +inf,8 sNaN,9 qNaN
  function automatic int ref_idx(input logic [63:0] x, input int ew, input int mw);
    logic [63:0] e, m, s, emax;
    emax = (64'd1 << ew) - 64'd1;
    e = (x >> mw) & emax;
    m = x & ((64'd1 << mw) - 64'd1);
    s = (x >> (ew + mw)) & 64'd1;
    if (e == emax) begin
      if (m == 64'd0) return (s != 64'd0) ? 0 : 7;
      return (m >= (64'd1 << (mw - 1))) ? 9 : 8;
    end
    if (e == 64'd0) begin
      if (m == 64'd0) return (s != 64'd0) ? 3 : 4;
      return (s != 64'd0) ? 2 : 5;
    end
    return (s != 64'd0) ? 1 : 6;
  endfunction

  // Returns {snan, nan, class[39:0]}
  function automatic logic [41:0] model(input logic [127:0] av, input logic [3:0] en);
    logic [39:0] c;
    logic        n;
    logic        sn;
    int          idx;
    c  = 40'd0;
    n  = 1'b0;
    sn = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) begin
        idx = ref_idx(64'(av[i*32 +: 32]), 8, 23);
        c[i*10 + idx] = 1'b1;
        if (idx >= 8) n = 1'b1;
        if (idx == 8) sn = 1'b1;
      end
    end
    return {sn, n, c};
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: return 32'($urandom);
      1: return {s, 8'hff, 23'($urandom)};
      2: return {s, 8'h00, 23'($urandom)};
      3: return {s, 8'hff, 23'h0};
      4: return {s, 8'h00, 23'h0};
      5: return {s, 8'hff, 1'b1, 22'($urandom)};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = rand_op();
    return v;
  endfunction

  // One clock: scoreboard the output, record accepted input, advance to next falling edge
  task automatic step();
    logic [41:0] m;
    #1;
    if (reset) begin
      q_class.delete();
      q_nan.delete();
      q_snan.delete();
      q_tag.delete();
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_class", 64'(class_o), 64'(prev_class));
        check("hold_flags", 64'({any_snan, any_nan}), 64'({prev_snan, prev_nan}));
        check("hold_tag", 64'(tag_o), 64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        pops++;
        if (q_tag.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          check("out_class", 64'(class_o), 64'(q_class.pop_front()));
          check("out_nan", 64'(any_nan), 64'(q_nan.pop_front()));
          check("out_snan", 64'(any_snan), 64'(q_snan.pop_front()));
          check("out_tag", 64'(tag_o), 64'(q_tag.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        accepts++;
        m = model(a, lane_en);
        q_class.push_back(m[39:0]);
        q_nan.push_back(m[40]);
        q_snan.push_back(m[41]);
        q_tag.push_back(tag);
      end
    end
    prev_hold  = !reset && out_valid && !out_ready;
    prev_class = class_o;
    prev_nan   = any_nan;
    prev_snan  = any_snan;
    prev_tag   = tag_o;
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [15:0] hv [4];
    logic [9:0]  hc [4];
    hv = '{16'h7e00, 16'h7c01, 16'h0001, 16'hfc00};
    hc = '{10'h200, 10'h100, 10'h020, 10'h001};

    reset = 1'b1; in_valid = 1'b0; a = 128'd0; lane_en = 4'h0; tag = 4'h0;
    out_ready = 1'b0; h_valid = 1'b0; h_a = 16'h0;
    @(negedge clk);
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_class", 64'(class_o), 64'd0);
    check("rst_flags", 64'({any_snan, any_nan}), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    // Test 1: specials on all lanes, exact latency
    a = {32'h00000001, 32'h7f800001, 32'h7fc00000, 32'hff800000};
    lane_en = 4'hf; tag = 4'h1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_not_early", 64'(out_valid), 64'd0);
    step();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_class", 64'(class_o), 64'({10'h020, 10'h100, 10'h200, 10'h001}));
    check("t1_nan", 64'(any_nan), 64'd1);
    check("t1_snan", 64'(any_snan), 64'd1);
    check("t1_tag", 64'(tag_o), 64'd1);
    step();

    // Test 2: partial lane enable
    a = {32'h7f800000, 32'hbf800000, 32'h00000000, 32'h80000000};
    lane_en = 4'b0101; tag = 4'h2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t2_class", 64'(class_o), 64'({10'h000, 10'h002, 10'h000, 10'h008}));
    check("t2_flags", 64'({any_snan, any_nan}), 64'd0);
    check("t2_tag", 64'(tag_o), 64'd2);
    step();

    // Test 3: back-to-back stream of 8
    base = pops;
    for (int i = 0; i < 8; i++) begin
      a = rand_vec(); lane_en = 4'($urandom); tag = 4'(i); in_valid = 1'b1;
      step();
      check("t3_in_ready", 64'(in_ready), 64'd1);
      check("t3_stream_valid", 64'(out_valid), (i >= 1) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < P; i++) step();
    check("t3_count", 64'(pops - base), 64'd8);
    check("t3_empty", 64'(q_tag.size()), 64'd0);

    // Test 4: backpressure fills the pipe, then drains in order
    out_ready = 1'b0;
    base = accepts;
    for (int i = 0; i < 6; i++) begin
      a = rand_vec(); lane_en = 4'hf; tag = 4'(8 + i); in_valid = 1'b1;
      step();
    end
    check("t4_buffered", 64'(accepts - base), 64'(P));
    check("t4_in_ready_low", 64'(in_ready), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    base = pops;
    for (int i = 0; i < 4; i++) step();
    check("t4_drained", 64'(pops - base), 64'(P));
    check("t4_empty", 64'(q_tag.size()), 64'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      a = rand_vec(); lane_en = 4'($urandom); tag = 4'($urandom);
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < P + 2; i++) step();
    check("rand_empty", 64'(q_tag.size()), 64'd0);

    // Test 5: reset with two transactions in flight
    out_ready = 1'b0;
    a = rand_vec(); lane_en = 4'hf; tag = 4'h3; in_valid = 1'b1;
    step();
    tag = 4'h4;
    step();
    tag = 4'h5; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_class", 64'(class_o), 64'd0);
    check("t5_tag", 64'(tag_o), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    base = pops;
    for (int i = 0; i < 4; i++) step();
    check("t5_no_stale", 64'(pops - base), 64'd0);

    // Test 6: FP16 build, single stage
    for (int i = 0; i < 4; i++) begin
      h_a = hv[i]; h_valid = 1'b1;
      step();
      h_valid = 1'b0;
      check("fp16_valid", 64'(h_out_valid), 64'd1);
      check("fp16_class", 64'(h_class), 64'(hc[i]));
      check("fp16_model", 64'(h_class), 64'd1 << ref_idx(64'(hv[i]), 5, 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
